// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : UART serial receiver. Synchronises rx_i, validates the start bit
//            at half-bit, samples data/parity/stop at mid-bit and hands each
//            character to the consumer on a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int SYNC_STAGES = 2  // rx_i synchroniser depth, must be >= 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        rx_i,
  output logic        busy_o,
  input  logic        cfg_en_i,
  input  logic [15:0] cfg_div_i,
  input  logic        cfg_parity_en_i,
  input  logic [1:0]  cfg_parity_sel_i,
  input  logic [1:0]  cfg_bits_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        err_parity_o,
  output logic        err_frame_o,
  output logic        err_overrun_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_WAIT   = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [15:0]            cnt_q, cnt_d;
  logic [2:0]             bitcnt_q, bitcnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   acc_q, acc_d;
  logic                   perr_q, perr_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ep_q, ep_d;
  logic                   ef_q, ef_d;
  logic                   eo_q, eo_d;

  logic                   rxs;
  logic                   sample;
  logic                   exp_par;
  logic [2:0]             last_bit;

  // Synchroniser for the asynchronous line; resets to the idle (high) level
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) sync_q <= '1;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
  end

  assign rxs      = sync_q[SYNC_STAGES-1];
  // Index of the final data bit: 8 data bits for code 00 down to 5 for 11
  assign last_bit = 3'd7 - {1'b0, cfg_bits_i};
  // Start bit is checked at half-bit; restarting the count there centres later samples
  assign sample   = (state_q == S_START) ? (cnt_q == (cfg_div_i >> 1))
                                         : (cnt_q == cfg_div_i);

  // Expected parity bit for the current accumulator and parity mode
  always_comb begin
    exp_par = 1'b0;
    case (cfg_parity_sel_i)
      2'b00:   exp_par = ~acc_q;
      2'b01:   exp_par = acc_q;
      2'b10:   exp_par = 1'b0;
      default: exp_par = 1'b1;
    endcase
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    acc_d    = acc_q;
    perr_d   = perr_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ep_d     = 1'b0;
    ef_d     = 1'b0;
    eo_d     = 1'b0;
    cnt_d    = 16'd0;

    if (valid_q && rx_ready_i) valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        bitcnt_d = 3'd0;
        shift_d  = 8'd0;
        acc_d    = 1'b0;
        perr_d   = 1'b0;
        if (cfg_en_i && !rxs) state_d = S_START;
      end
      S_START: begin
        // A high line at half-bit is a glitch: drop back silently
        if (sample) state_d = rxs ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (sample) begin
          shift_d[bitcnt_q] = rxs;
          acc_d             = acc_q ^ rxs;
          bitcnt_d          = bitcnt_q + 3'd1;
          if (bitcnt_q == last_bit) state_d = cfg_parity_en_i ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (sample) begin
          perr_d  = (rxs != exp_par);
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        // Completion is skipped when the receiver is being disabled
        if (sample && cfg_en_i) begin
          if (!valid_q || rx_ready_i) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            eo_d = 1'b1;
          end
          ep_d    = perr_q;
          ef_d    = ~rxs;
          state_d = rxs ? S_IDLE : S_WAIT;
        end
      end
      S_WAIT: begin
        // Hold off until the line returns high so a break yields one frame
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (!cfg_en_i) state_d = S_IDLE;

    if (state_d == state_q && cnt_q != cfg_div_i) cnt_d = cnt_q + 16'd1;
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= 16'd0;
      bitcnt_q <= 3'd0;
      shift_q  <= 8'd0;
      acc_q    <= 1'b0;
      perr_q   <= 1'b0;
      data_q   <= 8'd0;
      valid_q  <= 1'b0;
      ep_q     <= 1'b0;
      ef_q     <= 1'b0;
      eo_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      acc_q    <= acc_d;
      perr_q   <= perr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ep_q     <= ep_d;
      ef_q     <= ef_d;
      eo_q     <= eo_d;
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign rx_data_o     = data_q;
  assign rx_valid_o    = valid_q;
  // Error pulses are registered so they line up with rx_valid_o rising
  assign err_parity_o  = ep_q;
  assign err_frame_o   = ef_q;
  assign err_overrun_o = eo_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx: directed vector table, corner
//            sequences and randomized frames against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx = 1'b1;
  logic        en = 1'b0;
  logic [15:0] div = 16'd15;
  logic        pen = 1'b0;
  logic [1:0]  psel = 2'b00;
  logic [1:0]  bits = 2'b00;
  logic        rdy = 1'b1;
  logic        busy, valid, perr, ferr, ovr;
  logic [7:0]  data;

  int total = 0;
  int bad   = 0;

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clk_i(clk), .rstn_i(rstn), .rx_i(rx), .busy_o(busy),
    .cfg_en_i(en), .cfg_div_i(div), .cfg_parity_en_i(pen),
    .cfg_parity_sel_i(psel), .cfg_bits_i(bits),
    .rx_data_o(data), .rx_valid_o(valid), .rx_ready_i(rdy),
    .err_parity_o(perr), .err_frame_o(ferr), .err_overrun_o(ovr)
  );

  always #5 clk = ~clk;

  // Monitor: samples just after the falling edge, where inputs and outputs are settled
  logic [7:0] got[$];
  int n_pe = 0, n_fe = 0, n_ov = 0;
  int cyc = 0, rise_cyc = -1;
  logic prev_valid = 1'b0;
  always begin
    @(negedge clk);
    #1;
    cyc++;
    if (rstn) begin
      if (valid && rdy) got.push_back(data);
      if (perr) n_pe++;
      if (ferr) n_fe++;
      if (ovr)  n_ov++;
      if (valid && !prev_valid) rise_cyc = cyc;
      prev_valid = valid;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference for the parity bit a correct transmitter would send
  function automatic logic model_parity(input logic [7:0] d, input logic [1:0] sel);
    int ones;
    ones = $countones(d);
    case (sel)
      2'b00:   return (ones % 2) == 0;
      2'b01:   return (ones % 2) == 1;
      2'b10:   return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  int fall_cyc = 0;

  task automatic send_frame(input logic [7:0] d, input int nb, input logic pe,
                            input logic pbit, input logic stop);
    int p;
    p = int'(div) + 1;
    @(negedge clk);
    rx = 1'b0;
    fall_cyc = cyc;
    repeat (p) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      rx = d[i];
      repeat (p) @(negedge clk);
    end
    if (pe) begin
      rx = pbit;
      repeat (p) @(negedge clk);
    end
    rx = stop;
    repeat (p) @(negedge clk);
    rx = 1'b1;
    repeat (2 * p) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle"}, int'(busy), 0);
  endtask

  task automatic check_frame(input string name, input int h0, input int pe0,
                             input int fe0, input int ov0, input logic [7:0] ed,
                             input int epe, input int efe);
    int last;
    chk({name, "_count"}, got.size() - h0, 1);
    last = (got.size() > h0) ? int'(got[got.size()-1]) : -1;
    chk({name, "_data"}, last, int'(ed));
    chk({name, "_perr"}, n_pe - pe0, epe);
    chk({name, "_ferr"}, n_fe - fe0, efe);
    chk({name, "_ovr"},  n_ov - ov0, 0);
  endtask

  typedef struct {
    logic [15:0] div;
    logic [1:0]  bits;
    logic        pen;
    logic [1:0]  sel;
    logic [7:0]  d;
    logic        pbit;
    logic        stop;
    logic [7:0]  exp_d;
    logic        exp_pe;
    logic        exp_fe;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int h0, pe0, fe0, ov0, p, nb, ep, ef;
    logic [7:0] d, md;
    logic fl, st, pb;

    //            div    bits  pen   sel    data   pbit  stop  exp_d  pe    fe
    tbl[0] = '{16'd15, 2'b00, 1'b0, 2'b00, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{16'd15, 2'b00, 1'b1, 2'b01, 8'h03, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
    tbl[2] = '{16'd15, 2'b00, 1'b1, 2'b01, 8'h03, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
    tbl[3] = '{16'd7,  2'b11, 1'b0, 2'b00, 8'h1F, 1'b0, 1'b1, 8'h1F, 1'b0, 1'b0};
    tbl[4] = '{16'd7,  2'b01, 1'b0, 2'b00, 8'hFF, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0};
    tbl[5] = '{16'd7,  2'b10, 1'b1, 2'b00, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
    tbl[6] = '{16'd7,  2'b00, 1'b1, 2'b10, 8'h55, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0};
    tbl[7] = '{16'd7,  2'b00, 1'b1, 2'b11, 8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
    tbl[8] = '{16'd7,  2'b00, 1'b0, 2'b00, 8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_data",  int'(data), 0);
    chk("rst_errs",  int'({perr, ferr, ovr}), 0);
    rstn = 1'b1;
    en   = 1'b1;
    repeat (3) @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      div = tbl[i].div; bits = tbl[i].bits; pen = tbl[i].pen; psel = tbl[i].sel;
      h0 = got.size(); pe0 = n_pe; fe0 = n_fe; ov0 = n_ov;
      send_frame(tbl[i].d, 8 - int'(tbl[i].bits), tbl[i].pen, tbl[i].pbit, tbl[i].stop);
      wait_idle($sformatf("v%0d", i));
      check_frame($sformatf("v%0d", i), h0, pe0, fe0, ov0, tbl[i].exp_d,
                  int'(tbl[i].exp_pe), int'(tbl[i].exp_fe));
      if (i == 0) begin
        // ~9.5 bit periods of 16 clk plus synchroniser latency
        chk("v0_latency_window",
            int'((rise_cyc - fall_cyc) >= 150 && (rise_cyc - fall_cyc) <= 162), 1);
        chk("v0_valid_dropped", int'(valid), 0);
      end
    end

    // Start-bit glitch: 5 clk low pulse
    div = 16'd15; bits = 2'b00; pen = 1'b0; psel = 2'b00;
    h0 = got.size(); pe0 = n_pe; fe0 = n_fe; ov0 = n_ov;
    @(negedge clk); rx = 1'b0;
    repeat (5) @(negedge clk); rx = 1'b1;
    chk("glitch_busy_seen", int'(busy), 1);
    repeat (48) @(negedge clk);
    chk("glitch_busy_low", int'(busy), 0);
    chk("glitch_no_char",  got.size() - h0, 0);
    chk("glitch_no_err",   (n_pe - pe0) + (n_fe - fe0) + (n_ov - ov0), 0);

    // Break: line low for 20 bit periods
    h0 = got.size(); pe0 = n_pe; fe0 = n_fe; ov0 = n_ov;
    @(negedge clk); rx = 1'b0;
    repeat (20 * 16) @(negedge clk);
    chk("break_busy_held", int'(busy), 1);
    rx = 1'b1;
    repeat (48) @(negedge clk);
    chk("break_busy_low", int'(busy), 0);
    check_frame("break", h0, pe0, fe0, ov0, 8'h00, 0, 1);

    // Overrun with consumer stalled
    rdy = 1'b0;
    h0 = got.size(); ov0 = n_ov;
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
    wait_idle("ovr");
    chk("ovr_valid_held", int'(valid), 1);
    chk("ovr_data_kept",  int'(data), 32'h11);
    chk("ovr_pulse",      n_ov - ov0, 1);
    @(negedge clk); rdy = 1'b1;
    @(negedge clk); rdy = 1'b0;
    repeat (2) @(negedge clk);
    chk("ovr_valid_fell", int'(valid), 0);
    chk("ovr_handshake",  got.size() - h0, 1);
    chk("ovr_hs_data",    (got.size() > h0) ? int'(got[got.size()-1]) : -1, 32'h11);
    rdy = 1'b1;

    // 5-bit frame, then disable during the 2nd data bit of the next frame
    bits = 2'b11;
    h0 = got.size(); pe0 = n_pe; fe0 = n_fe; ov0 = n_ov;
    send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b1);
    wait_idle("b5");
    check_frame("b5", h0, pe0, fe0, ov0, 8'h1F, 0, 0);
    h0 = got.size(); pe0 = n_pe; fe0 = n_fe;
    @(negedge clk); rx = 1'b0;
    repeat (16) @(negedge clk); rx = 1'b1;
    repeat (16) @(negedge clk); rx = 1'b0;
    repeat (8) @(negedge clk);
    chk("dis_busy_before", int'(busy), 1);
    en = 1'b0;
    repeat (2) @(negedge clk);
    chk("dis_busy_fell", int'(busy), 0);
    rx = 1'b1;
    repeat (64) @(negedge clk);
    en = 1'b1;
    repeat (32) @(negedge clk);
    chk("dis_no_char", got.size() - h0, 0);
    chk("dis_no_err",  (n_pe - pe0) + (n_fe - fe0), 0);

    // Randomized frames against the behavioural model
    for (int k = 0; k < 40; k++) begin
      div  = 16'($urandom_range(2, 12));
      bits = 2'($urandom_range(0, 3));
      pen  = 1'($urandom_range(0, 1));
      psel = 2'($urandom_range(0, 3));
      d    = 8'($urandom);
      fl   = ($urandom_range(0, 3) == 0);
      st   = ($urandom_range(0, 4) != 0);
      nb   = 8 - int'(bits);
      md   = d & 8'((1 << nb) - 1);
      pb   = model_parity(md, psel) ^ fl;
      ep   = (pen && fl) ? 1 : 0;
      ef   = st ? 0 : 1;
      h0 = got.size(); pe0 = n_pe; fe0 = n_fe; ov0 = n_ov;
      send_frame(d, nb, pen, pb, st);
      wait_idle($sformatf("r%0d", k));
      check_frame($sformatf("r%0d", k), h0, pe0, fe0, ov0, md, ep, ef);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the bench can never hang
  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
